dma_axil_channel: RTL and testbench

- Single DMA copy engine: reads N 64-bit beats from a source address and writes each beat to a destination address, one beat at a time (read, then write).
- One instance per stream channel. Its master-side port drives one slot of the DMA AXI-lite arbiter: wvalid/wstrb/wdata/waddr, rready/raddr and abort.
- Configured by register-block inputs; reports busy/done/aborted status back.

---
 rtl/common_cells_pkg.sv | 15 +
 rtl/dma_axil_ch_watchdog.sv | 47 ++++
 rtl/dma_axil_channel.sv | 182 ++++++++++++++++++
 tb/tb_dma_axil_channel.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_cells_pkg.sv
// Shared encodings for the DMA datapath blocks.
// Holds the DMA channel FSM state width and encodings.
package common_cells_pkg;

   localparam int DMA_CH_FSM_WIDTH = 3;

   typedef enum logic [DMA_CH_FSM_WIDTH-1:0] {
      FSM_DMA_CH_IDLE     = 3'd0,
      FSM_DMA_CH_RD       = 3'd1,
      FSM_DMA_CH_WR       = 3'd2,
      FSM_DMA_CH_DONE     = 3'd3,
      FSM_DMA_CH_ABORTING = 3'd4
   } dma_ch_fsm_e;

endpackage

// File: rtl/dma_axil_ch_watchdog.sv
// Stall watchdog for one DMA channel: counts consecutive stalled
// bus cycles and flags when the limit is reached.
// Ports: clk_i, rst_i (sync, active-high), en_i (clock enable),
//   active_i (channel waits on a handshake), progress_i (handshake
//   this cycle), hit_o (limit reached this cycle).
module dma_axil_ch_watchdog
   import common_cells_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic active_i,
   input  logic progress_i,
   output logic hit_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of earlier stalled cycles, so the
   // current cycle is stall number cnt_q+1.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         if (!active_i || progress_i) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = en_i && active_i && !progress_i &&
                  (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dma_axil_channel.sv
// Single-beat-at-a-time DMA copy channel driving one arbiter slot.
// Ports: aclk/areset (sync, active-high)/aenable; i_start, i_src_addr,
//   i_dst_addr, i_len, i_abort_req config; o_busy/o_done/o_aborted
//   status; o_abort, AXI-lite read (rready/raddr/rvalid/rdata) and
//   write (wvalid/wstrb/wdata/waddr/wready) master side.
// Optional stall timeout with o_timeout: define DMA_AXIL_CH_TIMEOUT_EN.
module dma_axil_channel
   import common_cells_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 16
`ifdef DMA_AXIL_CH_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  aenable,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_src_addr,
   input  logic [ADDR_WIDTH-1:0] i_dst_addr,
   input  logic [LEN_WIDTH-1:0]  i_len,
   input  logic                  i_abort_req,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_aborted,
   output logic                  o_abort,
   output logic                  o_axil_rready,
   output logic [ADDR_WIDTH-1:0] o_axil_raddr,
   input  logic                  i_axil_rvalid,
   input  logic [DATA_WIDTH-1:0] i_axil_rdata,
   output logic                  o_axil_wvalid,
   output logic [STRB_WIDTH-1:0] o_axil_wstrb,
   output logic [DATA_WIDTH-1:0] o_axil_wdata,
   output logic [ADDR_WIDTH-1:0] o_axil_waddr,
   input  logic                  i_axil_wready
`ifdef DMA_AXIL_CH_TIMEOUT_EN
   ,
   output logic                  o_timeout
`endif
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(STRB_WIDTH);

   dma_ch_fsm_e state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic hs;
   logic tmo_hit;
   logic abort_go;

   assign hs = ((state_q == FSM_DMA_CH_RD) && i_axil_rvalid) ||
               ((state_q == FSM_DMA_CH_WR) && i_axil_wready);

`ifdef DMA_AXIL_CH_TIMEOUT_EN
   logic tmo_q, tmo_d;

   dma_axil_ch_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (aclk),
      .rst_i     (areset),
      .en_i      (aenable),
      .active_i  ((state_q == FSM_DMA_CH_RD) ||
                  (state_q == FSM_DMA_CH_WR)),
      .progress_i(hs),
      .hit_o     (tmo_hit)
   );

   // Remembers whether the current ABORTING visit came from a stall.
   always_comb begin
      tmo_d = tmo_q;
      if (aenable) begin
         tmo_d = (state_d == FSM_DMA_CH_ABORTING) && tmo_hit;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         tmo_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign o_timeout = (state_q == FSM_DMA_CH_ABORTING) && tmo_q;
`else
   assign tmo_hit = 1'b0;
`endif

   assign abort_go = i_abort_req || tmo_hit;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      data_d  = data_q;
      if (aenable) begin
         unique case (state_q)
            FSM_DMA_CH_IDLE: begin
               if (i_start) begin
                  if (i_len != '0) begin
                     src_d   = i_src_addr;
                     dst_d   = i_dst_addr;
                     len_d   = i_len;
                     state_d = FSM_DMA_CH_RD;
                  end else begin
                     state_d = FSM_DMA_CH_DONE;
                  end
               end
            end
            FSM_DMA_CH_RD: begin
               // abort wins over a same-cycle read handshake
               if (abort_go) begin
                  state_d = FSM_DMA_CH_ABORTING;
               end else if (i_axil_rvalid) begin
                  data_d  = i_axil_rdata;
                  state_d = FSM_DMA_CH_WR;
               end
            end
            FSM_DMA_CH_WR: begin
               // abort wins: the beat is dropped, counters untouched
               if (abort_go) begin
                  state_d = FSM_DMA_CH_ABORTING;
               end else if (i_axil_wready) begin
                  src_d   = src_q + ADDR_INC;
                  dst_d   = dst_q + ADDR_INC;
                  len_d   = len_q - 1'b1;
                  state_d = (len_q == LEN_WIDTH'(1)) ?
                            FSM_DMA_CH_DONE : FSM_DMA_CH_RD;
               end
            end
            FSM_DMA_CH_DONE: begin
               state_d = abort_go ? FSM_DMA_CH_ABORTING
                                  : FSM_DMA_CH_IDLE;
            end
            FSM_DMA_CH_ABORTING: begin
               state_d = FSM_DMA_CH_IDLE;
            end
            default: begin
               state_d = FSM_DMA_CH_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= FSM_DMA_CH_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         data_q  <= data_d;
      end
   end

   // Outputs decode registered state only, so they freeze with it.
   assign o_busy        = (state_q != FSM_DMA_CH_IDLE);
   assign o_done        = (state_q == FSM_DMA_CH_DONE);
   assign o_aborted     = (state_q == FSM_DMA_CH_ABORTING);
   assign o_abort       = (state_q == FSM_DMA_CH_ABORTING);
   assign o_axil_rready = (state_q == FSM_DMA_CH_RD);
   assign o_axil_raddr  = src_q;
   assign o_axil_wvalid = (state_q == FSM_DMA_CH_WR);
   assign o_axil_wstrb  = o_axil_wvalid ? '1 : '0;
   assign o_axil_wdata  = data_q;
   assign o_axil_waddr  = dst_q;

endmodule

// File: tb/tb_dma_axil_channel.sv
// Self-checking bench for dma_axil_channel with a scoreboard of
// expected read/write addresses and data per beat.
module tb_dma_axil_channel;

   localparam int AW = 16;
   localparam int DW = 64;
   localparam int SW = 8;
   localparam int LW = 16;
`ifdef DMA_AXIL_CH_TIMEOUT_EN
   localparam int TMO   = 16;
   localparam int STALL = 12;
`else
   localparam int STALL = 20;
`endif

   logic          aclk;
   logic          areset;
   logic          aenable;
   logic          i_start;
   logic [AW-1:0] i_src_addr;
   logic [AW-1:0] i_dst_addr;
   logic [LW-1:0] i_len;
   logic          i_abort_req;
   logic          o_busy;
   logic          o_done;
   logic          o_aborted;
   logic          o_abort;
   logic          o_axil_rready;
   logic [AW-1:0] o_axil_raddr;
   logic          i_axil_rvalid;
   logic [DW-1:0] i_axil_rdata;
   logic          o_axil_wvalid;
   logic [SW-1:0] o_axil_wstrb;
   logic [DW-1:0] o_axil_wdata;
   logic [AW-1:0] o_axil_waddr;
   logic          i_axil_wready;
`ifdef DMA_AXIL_CH_TIMEOUT_EN
   logic          o_timeout;
`endif

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] q_ra[$];
   logic [AW-1:0] q_wa[$];
   logic [DW-1:0] q_wd[$];
   logic [DW-1:0] q_rd[$];

   dma_axil_channel #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .STRB_WIDTH(SW),
      .LEN_WIDTH (LW)
`ifdef DMA_AXIL_CH_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .aclk         (aclk),
      .areset       (areset),
      .aenable      (aenable),
      .i_start      (i_start),
      .i_src_addr   (i_src_addr),
      .i_dst_addr   (i_dst_addr),
      .i_len        (i_len),
      .i_abort_req  (i_abort_req),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_aborted    (o_aborted),
      .o_abort      (o_abort),
      .o_axil_rready(o_axil_rready),
      .o_axil_raddr (o_axil_raddr),
      .i_axil_rvalid(i_axil_rvalid),
      .i_axil_rdata (i_axil_rdata),
      .o_axil_wvalid(o_axil_wvalid),
      .o_axil_wstrb (o_axil_wstrb),
      .o_axil_wdata (o_axil_wdata),
      .o_axil_waddr (o_axil_waddr),
      .i_axil_wready(i_axil_wready)
`ifdef DMA_AXIL_CH_TIMEOUT_EN
      ,
      .o_timeout    (o_timeout)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mkdata(input logic [15:0] seed,
                                          input int k);
      return {16'hDA7A, seed, 16'(k) ^ 16'h5A5A, 16'hC0DE ^ seed};
   endfunction

   task automatic all_zero(input string tag);
      chk({tag, "_busy"},    o_busy, 0);
      chk({tag, "_done"},    o_done, 0);
      chk({tag, "_aborted"}, o_aborted, 0);
      chk({tag, "_abort"},   o_abort, 0);
      chk({tag, "_rready"},  o_axil_rready, 0);
      chk({tag, "_raddr"},   o_axil_raddr, 0);
      chk({tag, "_wvalid"},  o_axil_wvalid, 0);
      chk({tag, "_wstrb"},   o_axil_wstrb, 0);
      chk({tag, "_wdata"},   o_axil_wdata, 0);
      chk({tag, "_waddr"},   o_axil_waddr, 0);
   endtask

   task automatic flush();
      q_ra.delete();
      q_wa.delete();
      q_wd.delete();
      q_rd.delete();
   endtask

   // Pushes the per-beat expectations, then pulses start for a cycle.
   task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] len, input logic [15:0] seed);
      for (int k = 0; k < int'(len); k++) begin
         q_ra.push_back(src + 16'(8 * k));
         q_wa.push_back(dst + 16'(8 * k));
         q_wd.push_back(mkdata(seed, k));
         q_rd.push_back(mkdata(seed, k));
      end
      @(negedge aclk);
      i_start    = 1'b1;
      i_src_addr = src;
      i_dst_addr = dst;
      i_len      = len;
      @(negedge aclk);
      i_start    = 1'b0;
   endtask

   task automatic wait_rd();
      int n = 0;
      while (o_axil_rready !== 1'b1 && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("rd_request", o_axil_rready, 1);
   endtask

   task automatic wait_wr();
      int n = 0;
      while (o_axil_wvalid !== 1'b1 && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("wr_request", o_axil_wvalid, 1);
   endtask

   task automatic do_read();
      logic [AW-1:0] a;
      wait_rd();
      a = q_ra.pop_front();
      chk("raddr", o_axil_raddr, a);
      chk("busy_rd", o_busy, 1);
      chk("done_in_rd", o_done, 0);
      @(negedge aclk);
      chk("raddr_hold", o_axil_raddr, a);
      chk("wvalid_in_rd", o_axil_wvalid, 0);
      i_axil_rvalid = 1'b1;
      i_axil_rdata  = q_rd.pop_front();
      @(negedge aclk);
      i_axil_rvalid = 1'b0;
      i_axil_rdata  = ~i_axil_rdata;
   endtask

   // Write phase: wready held low for wstall cycles, then one accept.
   task automatic do_write(input int wstall, input bit abort_w);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      wait_wr();
      a = q_wa.pop_front();
      d = q_wd.pop_front();
      for (int i = 0; i < wstall; i++) begin
         if (i > 0) @(negedge aclk);
         chk("wvalid_hold", o_axil_wvalid, 1);
         chk("waddr", o_axil_waddr, a);
         chk("wdata", o_axil_wdata, d);
         chk("wstrb", o_axil_wstrb, 8'hFF);
         chk("busy_wr", o_busy, 1);
      end
      @(negedge aclk);
      i_axil_wready = 1'b1;
      i_abort_req   = abort_w;
      @(negedge aclk);
      i_axil_wready = 1'b0;
      i_abort_req   = 1'b0;
   endtask

   task automatic do_beat(input int wstall, input bit abort_w);
      do_read();
      do_write(wstall, abort_w);
   endtask

   task automatic done_check(input string tag);
      chk({tag, "_done"}, o_done, 1);
      chk({tag, "_busy"}, o_busy, 1);
      chk({tag, "_aborted"}, o_aborted, 0);
      @(negedge aclk);
      chk({tag, "_done_clr"}, o_done, 0);
      chk({tag, "_idle"}, o_busy, 0);
   endtask

   initial begin
      areset        = 1'b1;
      aenable       = 1'b1;
      i_start       = 1'b0;
      i_src_addr    = '0;
      i_dst_addr    = '0;
      i_len         = '0;
      i_abort_req   = 1'b0;
      i_axil_rvalid = 1'b0;
      i_axil_rdata  = '0;
      i_axil_wready = 1'b0;
      repeat (3) @(negedge aclk);
      all_zero("reset");
`ifdef DMA_AXIL_CH_TIMEOUT_EN
      chk("reset_timeout", o_timeout, 0);
`endif
      areset = 1'b0;

      // basic copy
      start_xfer(16'h0100, 16'h0800, 16'd3, 16'h0001);
      do_beat(1, 1'b0);
      do_beat(1, 1'b0);
      do_beat(1, 1'b0);
      done_check("basic");

      // zero length
      start_xfer(16'h0200, 16'h0300, 16'd0, 16'h0002);
      chk("zlen_rready", o_axil_rready, 0);
      chk("zlen_wvalid", o_axil_wvalid, 0);
      done_check("zlen");
      chk("zlen_rready2", o_axil_rready, 0);
      chk("zlen_wvalid2", o_axil_wvalid, 0);

      // abort in idle is ignored
      i_abort_req = 1'b1;
      @(negedge aclk);
      i_abort_req = 1'b0;
      chk("idle_abort_busy", o_busy, 0);
      chk("idle_abort_aborted", o_aborted, 0);
      chk("idle_abort_abort", o_abort, 0);

      // stall during WR of beat 1
      start_xfer(16'h0400, 16'h0A00, 16'd2, 16'h0003);
      do_beat(STALL, 1'b0);
      do_beat(1, 1'b0);
      done_check("stall");

      // aenable low freezes; start while busy ignored
      start_xfer(16'h0500, 16'h0B00, 16'd1, 16'h0004);
      wait_rd();
      aenable       = 1'b0;
      i_axil_rvalid = 1'b1;
      i_axil_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      i_start       = 1'b1;
      i_src_addr    = 16'h7770;
      i_dst_addr    = 16'h6660;
      i_len         = 16'd9;
      repeat (3) begin
         @(negedge aclk);
         chk("freeze_rready", o_axil_rready, 1);
         chk("freeze_wvalid", o_axil_wvalid, 0);
      end
      aenable       = 1'b1;
      i_axil_rvalid = 1'b0;
      @(negedge aclk);
      i_start = 1'b0;
      do_beat(1, 1'b0);
      done_check("freeze");

      // abort with wready on beat 2 of 5
      start_xfer(16'h0100, 16'h0800, 16'd5, 16'h0005);
      do_beat(1, 1'b0);
      do_beat(1, 1'b1);
      flush();
      chk("abort_o_abort", o_abort, 1);
      chk("abort_aborted", o_aborted, 1);
      chk("abort_rready", o_axil_rready, 0);
      chk("abort_wvalid", o_axil_wvalid, 0);
      chk("abort_done", o_done, 0);
`ifdef DMA_AXIL_CH_TIMEOUT_EN
      chk("abort_no_timeout", o_timeout, 0);
`endif
      @(negedge aclk);
      chk("abort_clr", o_abort, 0);
      chk("abort_aborted_clr", o_aborted, 0);
      chk("abort_done_after", o_done, 0);
      chk("abort_idle", o_busy, 0);

      // restart after abort
      start_xfer(16'h0600, 16'h0C00, 16'd1, 16'h0006);
      do_beat(1, 1'b0);
      done_check("restart");

      // address wrap, then reset mid-WR
      start_xfer(16'hFFF8, 16'h1000, 16'd2, 16'h0007);
      do_beat(1, 1'b0);
      chk("wrap_model", q_ra[0], 16'h0000);
      do_read();
      wait_wr();
      areset = 1'b1;
      @(negedge aclk);
      all_zero("midreset");
      areset = 1'b0;
      flush();
      @(negedge aclk);
      all_zero("post_reset");

`ifdef DMA_AXIL_CH_TIMEOUT_EN
      // read never answered
      start_xfer(16'h0100, 16'h0200, 16'd1, 16'h0008);
      for (int i = 0; i < TMO; i++) begin
         chk("tmo_rready", o_axil_rready, 1);
         chk("tmo_early", o_abort, 0);
         @(negedge aclk);
      end
      flush();
      chk("tmo_abort", o_abort, 1);
      chk("tmo_aborted", o_aborted, 1);
      chk("tmo_flag", o_timeout, 1);
      chk("tmo_done", o_done, 0);
      @(negedge aclk);
      chk("tmo_flag_clr", o_timeout, 0);
      chk("tmo_idle", o_busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
